// File: rtl/cmd_confirm.sv
// ---------------------------------------------------------------------------
// cmd_confirm
//   Qualifies a filtered, clk-synchronous command level. A command is
//   accepted only after it has been sampled high on CONFIRM_CYCLES
//   consecutive edges. When accepted, the block drives a registered level
//   and one-cycle rise/fall pulses. It records the on-time of each normally
//   completed command. It flags a stuck-on fault when the command stays high
//   for TIMEOUT_CYCLES consecutive edges (TIMEOUT_CYCLES = 0 disables it).
//
// Handshake: none. "in" is a plain level input. Every output is a registered
//   level or a one-cycle pulse, valid in the cycle after the edge that
//   produced it.
//
// Ports:
//   clk        in   system clock, rising edge
//   aclr       in   asynchronous reset, active low
//   en         in   channel enable; low forces idle at the next edge
//   in         in   filtered command level
//   out        out  qualified command level
//   rise       out  one-cycle pulse on out 0->1
//   fall       out  one-cycle pulse on out 1->0
//   fault      out  stuck-on flag, held while faulted
//   dur        out  on-time (clk edges) of the last normally completed command
//   dbg_state  out  current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module cmd_confirm #(
  parameter int CNT_WIDTH      = 16,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 en,
  input  logic                 in,
  output logic                 out,
  output logic                 rise,
  output logic                 fall,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] dur,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CONF_LAST = CNT_WIDTH'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic                 TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 out_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 fault_q;
  logic [CNT_WIDTH-1:0] dur_q;

  // The run counter saturates at all-ones and never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      fault_q <= 1'b0;
      dur_q   <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!en) begin
        // Disable wins over everything. A live command ends with a fall
        // pulse, but that on-time is not a normal completion, so dur keeps
        // its old value.
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        fault_q <= 1'b0;
        if (state_q == ST_ACTIVE) begin
          fall_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in) begin
              state_q <= ST_CONFIRM;
              cnt_q   <= CNT_WIDTH'(1);
            end
          end
          ST_CONFIRM: begin
            if (!in) begin
              // Glitch shorter than the confirm window: drop it silently.
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
              if (cnt_q == CONF_LAST) begin
                state_q <= ST_ACTIVE;
                out_q   <= 1'b1;
                rise_q  <= 1'b1;
              end
            end
          end
          ST_ACTIVE: begin
            if (!in) begin
              state_q <= ST_IDLE;
              out_q   <= 1'b0;
              fall_q  <= 1'b1;
              dur_q   <= cnt_q;
              cnt_q   <= '0;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
              state_q <= ST_FAULT;
              out_q   <= 1'b0;
              fall_q  <= 1'b1;
              fault_q <= 1'b1;
              cnt_q   <= cnt_d;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_FAULT: begin
            // Leaving the fault is quiet: out is already low, so no pulse.
            if (!in) begin
              state_q <= ST_IDLE;
              fault_q <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign out       = out_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign fault     = fault_q;
  assign dur       = dur_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cmd_confirm.sv
// ---------------------------------------------------------------------------
// tb_cmd_confirm
//   Directed bench for cmd_confirm (CONFIRM_CYCLES=4, TIMEOUT_CYCLES=20).
//   The reference model tracks only the length of the current high run and
//   derives the qualified level from it. Pulses are derived as level changes.
//   A compare process checks every cycle, and literal checks pin key points.
// ---------------------------------------------------------------------------
module tb_cmd_confirm;

  localparam int W    = 16;
  localparam int CONF = 4;
  localparam int TO   = 20;
  localparam logic [W-1:0] DMAX = '1;

  // ---------------- clock / reset ----------------
  logic         clk  = 1'b0;
  logic         aclr = 1'b0;
  logic         en   = 1'b0;
  logic         in   = 1'b0;
  logic         out;
  logic         rise;
  logic         fall;
  logic         fault;
  logic [W-1:0] dur;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  cmd_confirm #(
    .CNT_WIDTH      (W),
    .CONFIRM_CYCLES (CONF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .aclr      (aclr),
    .en        (en),
    .in        (in),
    .out       (out),
    .rise      (rise),
    .fall      (fall),
    .fault     (fault),
    .dur       (dur),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The qualified level depends only on the length of the current high run:
  // out is high once the run reaches CONF and stays high until the run
  // reaches TO, where it becomes a fault. dur takes the run length when an
  // accepted run ends by in going low.
  int           run     = 0;
  logic         m_out   = 1'b0;
  logic         m_rise  = 1'b0;
  logic         m_fall  = 1'b0;
  logic         m_fault = 1'b0;
  logic [W-1:0] m_dur   = '0;
  logic         m_prev  = 1'b0;

  always @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      run     = 0;
      m_out   = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_fault = 1'b0;
      m_dur   = '0;
    end else begin
      m_prev = m_out;
      if (en && !in && m_prev) m_dur = (run > int'(DMAX)) ? DMAX : W'(run);
      if (en && in) run = run + 1;
      else          run = 0;
      m_out   = (run >= CONF) && (TO == 0 || run < TO);
      m_fault = (TO != 0) && (run >= TO);
      m_rise  = m_out && !m_prev;
      m_fall  = !m_out && m_prev;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("out",   {15'd0, out},   {15'd0, m_out});
    check("rise",  {15'd0, rise},  {15'd0, m_rise});
    check("fall",  {15'd0, fall},  {15'd0, m_fall});
    check("fault", {15'd0, fault}, {15'd0, m_fault});
    check("dur",   dur,            m_dur);
  end

  // ---------------- driver ----------------
  // Apply inputs away from the edge, then return just after the sampling edge.
  task automatic tick(input logic e, input logic i);
    @(negedge clk);
    en = e;
    in = i;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset with in toggling.
    aclr = 1'b0;
    en   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in = ~in;
    end
    check("rst_out", {15'd0, out}, 16'd0);
    check("rst_flt", {15'd0, fault}, 16'd0);
    check("rst_dur", dur, 16'd0);
    @(negedge clk);
    in = 1'b0;
    @(posedge clk);
    #1 aclr = 1'b1;

    // Glitch of three high edges: rejected.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check("glitch_out", {15'd0, out}, 16'd0);
    tick(1'b1, 1'b0);
    check("glitch_fall", {15'd0, fall}, 16'd0);
    check("glitch_dur", dur, 16'd0);

    // Accept and duration: ten high edges.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check("acc_pre", {15'd0, out}, 16'd0);
    tick(1'b1, 1'b1);
    check("acc_out", {15'd0, out}, 16'd1);
    check("acc_rise", {15'd0, rise}, 16'd1);
    tick(1'b1, 1'b1);
    check("acc_rise_1cyc", {15'd0, rise}, 16'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    check("acc_fall", {15'd0, fall}, 16'd1);
    check("acc_dur", dur, 16'd10);
    tick(1'b1, 1'b0);
    check("acc_fall_1cyc", {15'd0, fall}, 16'd0);

    // Stuck-on fault after twenty high edges.
    for (int i = 0; i < 19; i++) tick(1'b1, 1'b1);
    check("to_pre_out", {15'd0, out}, 16'd1);
    tick(1'b1, 1'b1);
    check("to_out", {15'd0, out}, 16'd0);
    check("to_fall", {15'd0, fall}, 16'd1);
    check("to_fault", {15'd0, fault}, 16'd1);
    check("to_dur", dur, 16'd10);
    tick(1'b1, 1'b1);
    check("to_hold", {15'd0, fault}, 16'd1);
    tick(1'b1, 1'b0);
    check("to_clear", {15'd0, fault}, 16'd0);
    check("to_nofall", {15'd0, fall}, 16'd0);

    // Back-to-back commands.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    check("b2b_dur6", dur, 16'd6);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    check("b2b_out", {15'd0, out}, 16'd1);
    tick(1'b1, 1'b0);
    check("b2b_dur5", dur, 16'd5);

    // Enable drop while active at cnt=7.
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    check("en_out", {15'd0, out}, 16'd0);
    check("en_fall", {15'd0, fall}, 16'd1);
    check("en_dur", dur, 16'd5);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    check("en_hold", {15'd0, out}, 16'd0);

    // Async reset mid-command.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    check("ar_pre", {15'd0, out}, 16'd1);
    @(negedge clk);
    #2 aclr = 1'b0;
    #1;
    check("ar_out", {15'd0, out}, 16'd0);
    check("ar_dur", dur, 16'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 aclr = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check("ar_wait", {15'd0, out}, 16'd0);
    tick(1'b1, 1'b1);
    check("ar_out2", {15'd0, out}, 16'd1);
    check("ar_rise2", {15'd0, rise}, 16'd1);
    tick(1'b1, 1'b0);
    check("ar_dur2", dur, 16'd4);

    repeat (3) tick(1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
